// File: rtl/layer_two_pkg.sv
// Shared BNN definitions: top-level FSM encodings, layer geometry and flat-index helpers.
package layer_two_pkg;

  // Top-level FSM state encodings
  localparam logic [2:0] s_IDLE    = 3'b000;
  localparam logic [2:0] s_LOAD    = 3'b001;
  localparam logic [2:0] s_LAYER_1 = 3'b010;
  localparam logic [2:0] s_LAYER_2 = 3'b011;
  localparam logic [2:0] s_LAYER_3 = 3'b100;

  // Layer geometry
  localparam int unsigned L1_DIM = 14;
  localparam int unsigned L1_CH  = 8;
  localparam int unsigned L2_DIM = 7;
  localparam int unsigned L2_CH  = 16;
  localparam int unsigned KERNEL = 3;

  // Progress of one layer-two job
  typedef enum logic [1:0] {
    StRun,
    StFinished,
    StDone
  } l2_phase_e;

  // Flat bit index into the layer-one map: [ci][r][c]
  function automatic int unsigned l1_index(int unsigned ci, int unsigned r, int unsigned c);
    return ci * L1_DIM * L1_DIM + r * L1_DIM + c;
  endfunction

  // Flat bit index into the layer-two map: [co][r][c]
  function automatic int unsigned l2_index(int unsigned co, int unsigned r, int unsigned c);
    return co * L2_DIM * L2_DIM + r * L2_DIM + c;
  endfunction

  // Flat bit index into the layer-two weight vector: [kr][kc][ci][co]
  function automatic int unsigned w_index(int unsigned kr, int unsigned kc, int unsigned ci,
                                          int unsigned co, int unsigned in_ch,
                                          int unsigned out_ch);
    return ((kr * KERNEL + kc) * in_ch + ci) * out_ch + co;
  endfunction

endpackage

// File: rtl/layer_two_if.sv
// Bus between the top-level controller and the layer-two conv/pool stage.
interface layer_two_if #(
  parameter int unsigned IN_CH  = layer_two_pkg::L1_CH,
  parameter int unsigned OUT_CH = layer_two_pkg::L2_CH
) ();

  localparam int unsigned InBits  = IN_CH * layer_two_pkg::L1_DIM * layer_two_pkg::L1_DIM;
  localparam int unsigned WBits   = layer_two_pkg::KERNEL * layer_two_pkg::KERNEL * IN_CH * OUT_CH;
  localparam int unsigned OutBits = OUT_CH * layer_two_pkg::L2_DIM * layer_two_pkg::L2_DIM;

  logic [2:0]         state;
  logic [InBits-1:0]  layer_one_out;
  logic [WBits-1:0]   weights;
  logic [OutBits-1:0] layer_two_out;
  logic               done;

  // Controller side
  modport master (
    output state,
    output layer_one_out,
    output weights,
    input  layer_two_out,
    input  done
  );

  // Layer-two stage side
  modport slave (
    input  state,
    input  layer_one_out,
    input  weights,
    output layer_two_out,
    output done
  );

endinterface

// File: rtl/layer_two_popcount72.sv
// Purely combinational 72-input popcount built as a balanced adder tree.
module layer_two_popcount72 (
  input  logic [71:0] bits_i,
  output logic [6:0]  count_o
);

  logic [1:0] lvl1 [24];
  logic [2:0] lvl2 [12];
  logic [3:0] lvl3 [6];
  logic [4:0] lvl4 [3];

  // Triples -> pairs -> ... -> final three-way sum
  always_comb begin
    for (int i = 0; i < 24; i++) begin
      lvl1[i] = 2'(bits_i[3*i]) + 2'(bits_i[3*i+1]) + 2'(bits_i[3*i+2]);
    end
    for (int i = 0; i < 12; i++) begin
      lvl2[i] = 3'(lvl1[2*i]) + 3'(lvl1[2*i+1]);
    end
    for (int i = 0; i < 6; i++) begin
      lvl3[i] = 4'(lvl2[2*i]) + 4'(lvl2[2*i+1]);
    end
    for (int i = 0; i < 3; i++) begin
      lvl4[i] = 5'(lvl3[2*i]) + 5'(lvl3[2*i+1]);
    end
    count_o = 7'(lvl4[0]) + 7'(lvl4[1]) + 7'(lvl4[2]);
  end

endmodule

// File: rtl/layer_two.sv
// Layer-two BNN stage: 3x3xIN_CH XNOR-popcount conv, threshold, 2x2 OR max-pool.
// One conv window per cycle; four windows fold into one pooled output bit.
module layer_two
  import layer_two_pkg::*;
#(
  parameter int unsigned IN_CH     = L1_CH,
  parameter int unsigned OUT_CH    = L2_CH,
  parameter int unsigned THRESHOLD = 36
) (
  input logic       clk,
  input logic       rst_n,
  layer_two_if.slave bus_io
);

  localparam int unsigned NumTaps = KERNEL * KERNEL * IN_CH;
  localparam int unsigned InBits  = IN_CH * L1_DIM * L1_DIM;
  localparam int unsigned WBits   = NumTaps * OUT_CH;
  localparam int unsigned OutBits = OUT_CH * L2_DIM * L2_DIM;
  localparam int unsigned InIdxW  = $clog2(InBits);
  localparam int unsigned WIdxW   = $clog2(WBits);
  localparam int unsigned OutIdxW = $clog2(OutBits);
  localparam int unsigned TapIdxW = $clog2(NumTaps);
  localparam int unsigned CoW     = $clog2(OUT_CH);
  localparam int unsigned PosW    = $clog2(L2_DIM);

  l2_phase_e          phase_q;
  logic [CoW-1:0]     co_q;
  logic [PosW-1:0]    row_q;
  logic [PosW-1:0]    col_q;
  logic [1:0]         pool_cnt_q;
  logic               pool_acc_q;
  logic [OutBits-1:0] out_q;
  logic               done_q;

  logic [NumTaps-1:0] match;
  logic [6:0]         popcnt;
  logic               out_bit;
  logic [InIdxW-1:0]  in_idx;
  logic [WIdxW-1:0]   w_idx;
  logic [OutIdxW-1:0] out_idx;
  logic               tap;
  int                 r_tap;
  int                 c_tap;

  // Gather the window around the current conv centre and XNOR it with the kernel
  always_comb begin
    match  = '0;
    in_idx = '0;
    w_idx  = '0;
    tap    = 1'b0;
    r_tap  = 0;
    c_tap  = 0;
    for (int kr = 0; kr < int'(KERNEL); kr++) begin
      for (int kc = 0; kc < int'(KERNEL); kc++) begin
        for (int ci = 0; ci < int'(IN_CH); ci++) begin
          r_tap = 2 * int'(row_q) + int'(pool_cnt_q[1]) + kr - 1;
          c_tap = 2 * int'(col_q) + int'(pool_cnt_q[0]) + kc - 1;
          tap   = 1'b0;
          // Zero padding: out-of-bounds taps read 0 but still take part in the XNOR
          if (r_tap >= 0 && r_tap < int'(L1_DIM) && c_tap >= 0 && c_tap < int'(L1_DIM)) begin
            in_idx = InIdxW'(l1_index(ci, r_tap, c_tap));
            tap    = bus_io.layer_one_out[in_idx];
          end
          w_idx = WIdxW'(w_index(kr, kc, ci, 32'(co_q), IN_CH, OUT_CH));
          match[TapIdxW'((kr * int'(KERNEL) + kc) * int'(IN_CH) + ci)] =
              ~(tap ^ bus_io.weights[w_idx]);
        end
      end
    end
  end

  layer_two_popcount72 u_popcount (
    .bits_i  (match),
    .count_o (popcnt)
  );

  // Threshold and destination of the current pooled bit
  always_comb begin
    out_bit = (32'(popcnt) > THRESHOLD);
    out_idx = OutIdxW'(l2_index(32'(co_q), 32'(row_q), 32'(col_q)));
  end

  // Job sequencer: walks pool_cnt fastest, then col, row, co; holds whenever paused
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= StRun;
      co_q       <= '0;
      row_q      <= '0;
      col_q      <= '0;
      pool_cnt_q <= '0;
      pool_acc_q <= 1'b0;
      out_q      <= '0;
      done_q     <= 1'b0;
    end else if (bus_io.state == s_LAYER_2) begin
      case (phase_q)
        StRun: begin
          if (pool_cnt_q != 2'd3) begin
            pool_acc_q <= pool_acc_q | out_bit;
            pool_cnt_q <= pool_cnt_q + 2'd1;
          end else begin
            out_q[out_idx] <= pool_acc_q | out_bit;
            pool_acc_q     <= 1'b0;
            pool_cnt_q     <= '0;
            if (col_q == PosW'(L2_DIM - 1)) begin
              col_q <= '0;
              if (row_q == PosW'(L2_DIM - 1)) begin
                row_q <= '0;
                if (co_q == CoW'(OUT_CH - 1)) begin
                  co_q    <= '0;
                  phase_q <= StFinished;
                end else begin
                  co_q <= co_q + CoW'(1);
                end
              end else begin
                row_q <= row_q + PosW'(1);
              end
            end else begin
              col_q <= col_q + PosW'(1);
            end
          end
        end
        StFinished: begin
          done_q  <= 1'b1;
          phase_q <= StDone;
        end
        default: begin
          // StDone: sticky, no further writes
        end
      endcase
    end
  end

  assign bus_io.layer_two_out = out_q;
  assign bus_io.done          = done_q;

endmodule
